// File: rtl/pipe_stage6_feeder.sv
// Host-side feeder for stage 6: loads two operand banks, steps the stage index
// on finished edges, then streams captured accumulator and scalar results out.
module pipe_stage6_feeder #(
   parameter int WIDTH    = 16,
   parameter int PARALLEL = 3,
   parameter int TILE     = 128
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [4:0]                   cmd_stages,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic [PARALLEL*TILE*WIDTH-1:0] operandv1_o,
   output logic [PARALLEL*TILE*WIDTH-1:0] operandv2_o,
   output logic [4:0]                   stage_o,
   input  logic                         finished_i,
   input  logic [PARALLEL*TILE*WIDTH-1:0] acc_i,
   input  logic [PARALLEL*WIDTH-1:0]    scal_i,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_last,
   output logic                         busy_o
);

   localparam int NEL = PARALLEL * TILE;
   localparam int EW  = (TILE > 1) ? $clog2(TILE) : 1;
   localparam int LW  = (PARALLEL > 1) ? $clog2(PARALLEL) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [EW-1:0]    elem_q, elem_d;
   logic [LW-1:0]    lane_q, lane_d;
   logic             bank_q, bank_d;
   logic             sph_q, sph_d;
   logic [4:0]       nst_q, nst_d;
   logic [4:0]       stage_q, stage_d;
   logic             fin_q, fin_d;

   logic [WIDTH-1:0] v1_q   [NEL];
   logic [WIDTH-1:0] v2_q   [NEL];
   logic [WIDTH-1:0] acc_q  [NEL];
   logic [WIDTH-1:0] scal_q [PARALLEL];

   logic             load_beat, load_done, pass_done, last_pass;
   logic             out_beat, drain_done, elem_last, lane_last;
   logic [LW+EW-1:0] widx;

   // TILE is a power of two, so {lane, elem} is exactly lane*TILE + elem
   assign widx      = {lane_q, elem_q};
   assign elem_last = (elem_q == EW'(TILE - 1));
   assign lane_last = (lane_q == LW'(PARALLEL - 1));
   assign load_beat = (state_q == LOAD) && in_valid;
   assign load_done = load_beat && bank_q && lane_last && elem_last;
   assign pass_done = (state_q == RUN) && finished_i && !fin_q;
   assign last_pass = (stage_q == nst_q - 5'd1);
   assign out_beat  = (state_q == DRAIN) && out_ready;
   assign drain_done = out_beat && sph_q && lane_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (cmd_valid)               state_d = LOAD;
         LOAD:  if (load_done)               state_d = RUN;
         RUN:   if (pass_done && last_pass)  state_d = DRAIN;
         DRAIN: if (drain_done)              state_d = IDLE;
         default:                            state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == IDLE);
      in_ready  = (state_q == LOAD);
      busy_o    = (state_q != IDLE);
      out_valid = (state_q == DRAIN);
      out_last  = (state_q == DRAIN) && sph_q && lane_last;
      out_data  = '0;
      if (state_q == DRAIN)
         out_data = sph_q ? scal_q[lane_q] : acc_q[widx];
      stage_o   = stage_q;
   end

   // elem/lane counters are shared: load addressing first, then drain order
   always_comb begin
      elem_d  = elem_q;
      lane_d  = lane_q;
      bank_d  = bank_q;
      sph_d   = sph_q;
      nst_d   = nst_q;
      stage_d = stage_q;
      fin_d   = (state_q == RUN) ? finished_i : 1'b0;

      if ((state_q == IDLE) && cmd_valid)
         nst_d = (cmd_stages == 5'd0) ? 5'd1 : cmd_stages;

      if (pass_done)
         stage_d = last_pass ? 5'd0 : stage_q + 5'd1;

      if (load_beat || (out_beat && !sph_q)) begin
         if (elem_last) begin
            elem_d = '0;
            if (lane_last) begin
               lane_d = '0;
               if (state_q == LOAD) bank_d = ~bank_q;
               else                 sph_d  = 1'b1;
            end else begin
               lane_d = lane_q + 1'b1;
            end
         end else begin
            elem_d = elem_q + 1'b1;
         end
      end else if (out_beat && sph_q) begin
         if (lane_last) begin
            lane_d = '0;
            sph_d  = 1'b0;
         end else begin
            lane_d = lane_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         elem_q  <= '0;
         lane_q  <= '0;
         bank_q  <= 1'b0;
         sph_q   <= 1'b0;
         nst_q   <= '0;
         stage_q <= '0;
         fin_q   <= 1'b0;
      end else begin
         elem_q  <= elem_d;
         lane_q  <= lane_d;
         bank_q  <= bank_d;
         sph_q   <= sph_d;
         nst_q   <= nst_d;
         stage_q <= stage_d;
         fin_q   <= fin_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NEL; i++) begin
            v1_q[i]  <= '0;
            v2_q[i]  <= '0;
            acc_q[i] <= '0;
         end
         for (int unsigned l = 0; l < PARALLEL; l++)
            scal_q[l] <= '0;
      end else begin
         if (load_beat) begin
            if (bank_q) v2_q[widx] <= in_data;
            else        v1_q[widx] <= in_data;
         end
         if (pass_done && last_pass) begin
            for (int unsigned i = 0; i < NEL; i++)
               acc_q[i] <= acc_i[i*WIDTH +: WIDTH];
            for (int unsigned l = 0; l < PARALLEL; l++)
               scal_q[l] <= scal_i[l*WIDTH +: WIDTH];
         end
      end
   end

   for (genvar g = 0; g < NEL; g++) begin : g_flat
      assign operandv1_o[g*WIDTH +: WIDTH] = v1_q[g];
      assign operandv2_o[g*WIDTH +: WIDTH] = v2_q[g];
   end

endmodule

// File: tb/tb_pipe_stage6_feeder.sv
// Scoreboard bench for pipe_stage6_feeder with a small configuration
// (PARALLEL=2, TILE=4): directed cases followed by randomized commands.
module tb_pipe_stage6_feeder;

   localparam int W   = 16;
   localparam int P   = 2;
   localparam int T   = 4;
   localparam int NEL = P * T;
   localparam int NB  = 2 * NEL;
   localparam int BW  = NEL * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready;
   logic [4:0]    cmd_stages;
   logic          in_valid, in_ready;
   logic [W-1:0]  in_data;
   logic [BW-1:0] operandv1_o, operandv2_o;
   logic [4:0]    stage_o;
   logic          finished_i;
   logic [BW-1:0] acc_i;
   logic [P*W-1:0] scal_i;
   logic          out_valid, out_ready, out_last, busy_o;
   logic [W-1:0]  out_data;

   pipe_stage6_feeder #(.WIDTH(W), .PARALLEL(P), .TILE(T)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_stages(cmd_stages),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .operandv1_o(operandv1_o), .operandv2_o(operandv2_o),
      .stage_o(stage_o), .finished_i(finished_i),
      .acc_i(acc_i), .scal_i(scal_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [W-1:0] beats [NB];
   logic [W:0]   sbq [$];
   int           popped = 0;
   int           rdy_mode = 0;
   int           pidx = 0;
   logic         rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      vectors++;
      miscompares++;
      $display("FAIL %s: bound expired, got timeout expected completion", nm);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom % 2);
         default: begin out_ready = rdy_pat[pidx]; pidx = (pidx + 1) % 4; end
      endcase
   end

   // Monitor: pops an expected beat for each transfer, checks stability while stalled
   logic         held_v = 1'b0;
   logic [W-1:0] held_d;
   logic         held_l;
   always @(negedge clk) begin
      if (!rst) begin
         held_v = 1'b0;
      end else begin
         if (held_v && out_valid) begin
            chk("stall_data", BW'(out_data), BW'(held_d));
            chk("stall_last", BW'(out_last), BW'(held_l));
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               chk("unexpected_beat", BW'(out_data), BW'(1'b0) - BW'(1'b1));
            end else begin
               logic [W:0] e;
               e = sbq.pop_front();
               chk("out_data", BW'(out_data), BW'(e[W-1:0]));
               chk("out_last", BW'(out_last), BW'(e[W]));
            end
            popped++;
            held_v = 1'b0;
         end else if (out_valid) begin
            held_v = 1'b1;
            held_d = out_data;
            held_l = out_last;
         end else begin
            held_v = 1'b0;
         end
      end
   end

   task automatic check_idle_zero(input string nm);
      chk({nm, "_cmd_ready"}, BW'(cmd_ready), BW'(1'b1));
      chk({nm, "_in_ready"},  BW'(in_ready),  BW'(1'b0));
      chk({nm, "_busy"},      BW'(busy_o),    BW'(1'b0));
      chk({nm, "_stage"},     BW'(stage_o),   BW'(5'd0));
      chk({nm, "_out_valid"}, BW'(out_valid), BW'(1'b0));
      chk({nm, "_out_last"},  BW'(out_last),  BW'(1'b0));
      chk({nm, "_out_data"},  BW'(out_data),  BW'(16'd0));
      chk({nm, "_v1"},        operandv1_o,    '0);
      chk({nm, "_v2"},        operandv2_o,    '0);
   endtask

   task automatic check_banks(input string nm);
      logic [BW-1:0] e1, e2;
      for (int k = 0; k < NB; k++) begin
         if (k < NEL) e1[k*W +: W] = beats[k];
         else         e2[(k-NEL)*W +: W] = beats[k];
      end
      chk({nm, "_v1"}, operandv1_o, e1);
      chk({nm, "_v2"}, operandv2_o, e2);
   endtask

   task automatic send_cmd(input logic [4:0] s);
      int n = 0;
      cmd_stages = s;
      cmd_valid  = 1'b1;
      while (!cmd_ready && n < 50) begin tick(); n++; end
      if (n >= 50) timeout("cmd_handshake");
      tick();
      cmd_valid = 1'b0;
      chk("cmd_busy", BW'(busy_o), BW'(1'b1));
      chk("cmd_in_ready", BW'(in_ready), BW'(1'b1));
   endtask

   task automatic load(input int gap, input bit stray);
      int k = 0;
      int cyc = 0;
      logic acc;
      while (k < NB && cyc < 500) begin
         in_data = beats[k];
         case (gap)
            0:       in_valid = 1'b1;
            1:       in_valid = (cyc % 2) == 0;
            default: in_valid = 1'($urandom % 2);
         endcase
         if (stray) finished_i = (k < NB - 1) ? 1'($urandom % 2) : 1'b0;
         acc = in_valid && in_ready;
         tick();
         if (acc) k++;
         cyc++;
      end
      in_valid   = 1'b0;
      finished_i = 1'b0;
      if (k < NB) timeout("load");
      chk("run_entry_stage", BW'(stage_o), BW'(5'd0));
      chk("run_entry_in_ready", BW'(in_ready), BW'(1'b0));
      chk("run_entry_out_valid", BW'(out_valid), BW'(1'b0));
   endtask

   task automatic run_passes(input int nst, input int hold0, input bit directed);
      int n;
      for (int p = 0; p < nst; p++) begin
         int w;
         if (p == nst - 1) begin
            popped = 0;
            for (int i = 0; i < NEL; i++) begin
               logic [W-1:0] v;
               v = directed ? W'(100 + i) : W'($urandom);
               acc_i[i*W +: W] = v;
               sbq.push_back({1'b0, v});
            end
            for (int l = 0; l < P; l++) begin
               logic [W-1:0] v;
               v = directed ? W'(200 + l) : W'($urandom);
               scal_i[l*W +: W] = v;
               sbq.push_back({(l == P - 1), v});
            end
         end
         finished_i = 1'b1;
         w = (p == 0 && hold0 > 0) ? hold0 : 1 + int'($urandom % 3);
         tick();
         if (p == nst - 1) begin
            chk("drain_valid_after_capture", BW'(out_valid), BW'(1'b1));
            chk("drain_stage_zero", BW'(stage_o), BW'(5'd0));
            repeat (w - 1) tick();
            finished_i = 1'b0;
         end else begin
            chk("stage_advance", BW'(stage_o), BW'(p + 1));
            repeat (w - 1) tick();
            finished_i = 1'b0;
            chk("stage_after_level", BW'(stage_o), BW'(p + 1));
            chk("no_drain_yet", BW'(out_valid), BW'(1'b0));
            repeat (1 + int'($urandom % 2)) tick();
         end
      end
      n = 0;
      while (busy_o && n < 1000) begin tick(); n++; end
      if (n >= 1000) timeout("drain");
      chk("drain_beats", BW'(popped), BW'(NEL + P));
      chk("drain_queue_empty", BW'(sbq.size()), BW'(0));
      chk("post_drain_valid", BW'(out_valid), BW'(1'b0));
      chk("post_drain_cmd_ready", BW'(cmd_ready), BW'(1'b1));
      check_banks("post_drain");
   endtask

   initial begin
      rst = 1'b0; cmd_valid = 1'b0; cmd_stages = '0; in_valid = 1'b0; in_data = '0;
      finished_i = 1'b0; acc_i = '0; scal_i = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_idle_zero("reset");
      rst = 1'b1;
      tick();

      // reset mid-LOAD after 5 beats, then reload with fresh data
      for (int k = 0; k < NB; k++) beats[k] = W'(16'h5000 + k);
      send_cmd(5'd3);
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin in_data = beats[k]; tick(); end
      rst = 1'b0;
      #1;
      check_idle_zero("midload_reset");
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();

      // directed: stages=3, beats 1..16, acc 100..107, scal 200,201
      for (int k = 0; k < NB; k++) beats[k] = W'(k + 1);
      send_cmd(5'd3);
      load(0, 1'b0);
      check_banks("directed");
      run_passes(3, 0, 1'b1);

      // stages=0 behaves as one pass
      for (int k = 0; k < NB; k++) beats[k] = W'($urandom);
      send_cmd(5'd0);
      load(2, 1'b0);
      check_banks("stages0");
      run_passes(1, 0, 1'b0);

      // level-high finished for 10 cycles counts once
      send_cmd(5'd2);
      load(0, 1'b0);
      run_passes(2, 10, 1'b0);

      // out_ready pattern 1,0,0,1 during drain
      rdy_mode = 2; pidx = 0;
      send_cmd(5'd1);
      load(0, 1'b0);
      run_passes(1, 0, 1'b1);
      rdy_mode = 0;

      // stray finished in IDLE and LOAD, gapped in_valid
      finished_i = 1'b1;
      repeat (3) tick();
      for (int k = 0; k < NB; k++) beats[k] = W'($urandom);
      send_cmd(5'd2);
      load(1, 1'b1);
      check_banks("stray");
      repeat (3) tick();
      chk("stray_stage_hold", BW'(stage_o), BW'(5'd0));
      run_passes(2, 0, 1'b0);

      // randomized commands
      rdy_mode = 1;
      for (int it = 0; it < 6; it++) begin
         int s;
         s = int'($urandom % 6);
         for (int k = 0; k < NB; k++) beats[k] = W'($urandom);
         send_cmd(5'(s));
         load(2, 1'b1);
         check_banks("rand");
         run_passes((s == 0) ? 1 : s, 0, 1'b0);
      end

      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_stage6_feeder.md
Name: pipe_stage6_feeder

Overview:
- Host-side counterpart of the stage-6 timing wrapper.
- Accepts a command and an element stream from the host, assembles the two operand vector banks, and drives the stage index into stage 6.
- Steps through the requested number of stage passes, paced by stage 6's finished flag.
- Captures the final accumulator and scalar results, then streams them back out element by element with valid/ready.

Parameters:
WIDTH, 16, element bit width
PARALLEL, 3, lane count (parallel_size of stage 6)
TILE, 128, elements per lane vector (power of two)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offer
cmd_ready  out  1  high only in IDLE
cmd_stages  in  5  number of stage passes; 0 treated as 1
in_valid  in  1  load element valid
in_ready  out  1  high only in LOAD
in_data  in  WIDTH  load element
operandv1_o  out  PARALLEL*TILE*WIDTH  operand bank 1 to stage 6
operandv2_o  out  PARALLEL*TILE*WIDTH  operand bank 2 to stage 6
stage_o  out  5  current stage index to stage 6
finished_i  in  1  stage 6 finished (level)
acc_i  in  PARALLEL*TILE*WIDTH  stage 6 accumulator
scal_i  in  PARALLEL*WIDTH  stage 6 scalar
out_valid  out  1  result element valid
out_ready  in  1  result sink ready
out_data  out  WIDTH  result element
out_last  out  1  final result element
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, async):
  - State goes to IDLE.
  - All counters, operand banks, captured results, stage_o, out_valid, out_last and busy_o clear to 0.
  - Reset asserted mid-operation abandons the operation; no partial output follows.
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - cmd_ready=1.
  - A cmd_valid&cmd_ready handshake latches max(cmd_stages,1) into n_stages and moves to LOAD.
- LOAD:
  - in_ready=1. Each accepted beat (in_valid&in_ready) writes one element.
  - Beat k goes to bank k/(PARALLEL*TILE) (0→v1, 1→v2), lane (k mod PARALLEL*TILE)/TILE, element k mod TILE.
  - Implemented as nested elem/lane/bank counters.
  - After beat 2*PARALLEL*TILE-1 is accepted: next cycle is RUN with stage_o=0.
  - in_valid low inserts bubbles; no timeout.
- RUN:
  - Banks are held constant. stage_o holds the current stage.
  - A pass completes on a rising edge of finished_i: finished_i=1 while the registered copy fin_q=0.
  - fin_q is cleared on RUN entry, so a finished_i already high on entry counts once.
  - Level-high finished_i is counted once only.
  - finished_i edges in any other state are ignored.
  - On pass completion with stage_o < n_stages-1: stage_o increments the next cycle.
  - On pass completion with stage_o = n_stages-1: acc_i and scal_i are captured in that cycle, then the state moves to DRAIN.
  - stage_o returns to 0 on exit from RUN.
- DRAIN:
  - Emits PARALLEL*TILE accumulator elements, lane-major, element-minor, then PARALLEL scalars in lane order.
  - Total PARALLEL*TILE+PARALLEL beats.
  - out_valid is asserted the cycle after capture.
  - out_data/out_last stay stable while out_valid&!out_ready.
  - A beat transfers on out_valid&out_ready.
  - out_last=1 only on the final scalar beat. After it transfers: IDLE, out_valid=0.
- Widths: there is no arithmetic on data. Counters are sized to hold their maxima without wrap (stage counter 5 bits).
- busy_o = (state != IDLE).
- cmd_valid outside IDLE is not accepted. The host holds it until cmd_ready.

Test Plan (bench may use PARALLEL=2, TILE=4):
- Reset mid-LOAD after 5 beats → cmd_ready=1, all outputs 0. Reload then yields banks containing only the new data.
- cmd_stages=3, load beats 1..16, finished_i pulsed 3 times:
  - v1 lane0={1,2,3,4}, lane1={5,6,7,8}; v2 lane0={9..12}, lane1={13..16}.
  - stage_o sequence 0,1,2.
  - Drain of acc_i=elements 100..107, scal_i={200,201} → out_data 100..107,200,201, out_last only on 201.
- cmd_stages=0 → exactly one pass: drain after the first finished edge, stage_o stays 0.
- finished_i held high 10 cycles in RUN with cmd_stages=2 → only one advance (stage_o=1), no drain until a second rising edge.
- out_ready toggled 1,0,0,1 during drain → out_data held while stalled, no beat lost or duplicated, 10 total beats.
- in_valid gapped every other cycle during LOAD and finished_i pulsed while in LOAD or IDLE → load completes after 16 accepted beats, stray finished ignored, stage_o=0 on RUN entry.
